// File: rtl/grid_pkg.sv
// ----------------------------------------------------------------------------
// grid_pkg
// Types and constants shared by the Game-of-Life cell matrix and the
// grid_scan LED driver.
//   GRID_N        : array edge length (8)
//   grid_t        : [0:GRID_N-1][0:GRID_N-1] live-cell array, grid[r][c]
//   row_t         : one row / column drive vector, [0:GRID_N-1]
//   scan_state_t  : scan FSM states
//   max3()        : helper for sizing the dwell/blank timer
// ----------------------------------------------------------------------------
package grid_pkg;

    localparam int GRID_N = 8;
    localparam int ROW_W  = $clog2(GRID_N);

    typedef logic [0:GRID_N-1][0:GRID_N-1] grid_t;
    typedef logic [0:GRID_N-1]             row_t;

    typedef enum logic [1:0] {
        S_LOAD,
        S_BLANK,
        S_SHOW
    } scan_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/grid_scan_timer.sv
// ----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter with zero flag. Counts down by one per cycle and
// parks at zero; a load overrides counting.
//   clk      : clock, rising edge
//   _rst     : synchronous active-low reset (count -> 0)
//   i_load   : load i_value this cycle
//   i_value  : reload value
//   o_zero   : count is zero (last cycle of the current interval)
// ----------------------------------------------------------------------------
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         _rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/grid_scan.sv
// ----------------------------------------------------------------------------
// grid_scan
// Row-multiplexed 8x8 LED driver. Captures a tear-free snapshot of the cell
// matrix once per frame (LOAD), then for each row blanks all rows for
// BLANK_CYCLES cycles and lights the row for ROW_DWELL cycles.
//   clk        : clock, rising edge
//   _rst       : synchronous active-low reset
//   en         : scan enable; low blanks the display and restarts the frame
//   grid       : live-cell array from the matrix, grid[r][c]
//   row_sel    : one-hot row drive, active-high, zero while blanking
//   col_data   : column drive of the lit row, col_data[c] = snap[r][c]
//   frame_done : one-cycle pulse in the LOAD cycle after a completed frame
//   stable     : last two snapshots identical (GRID_STABLE_EN), else 0
// Optional feature macro: GRID_STABLE_EN
// ----------------------------------------------------------------------------
module grid_scan
    import grid_pkg::*;
#(
    parameter int ROW_DWELL    = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic  clk,
    input  logic  _rst,
    input  logic  en,
    input  grid_t grid,
    output row_t  row_sel,
    output row_t  col_data,
    output logic  frame_done,
    output logic  stable
);

    localparam int unsigned T_MAX = max3(ROW_DWELL, BLANK_CYCLES, 1);
    localparam int          TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0]    DWELL_LD = TW'(ROW_DWELL - 1);
    localparam logic [TW-1:0]    BLANK_LD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID_N - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    scan_state_t      r_state, w_state_n;
    logic [ROW_W-1:0] r_row, w_row_n;
    grid_t            r_snap, w_snap_n;
    row_t             r_row_sel, r_col_data;
    row_t             w_row_sel_n, w_col_n;
    logic             r_frame_done, w_done_n;
    logic             w_capture;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             w_tmr_zero;

    scan_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        ._rst    (_rst),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_state      <= S_LOAD;
            r_row        <= '0;
            r_snap       <= '0;
            r_row_sel    <= '0;
            r_col_data   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_row        <= w_row_n;
            r_snap       <= w_snap_n;
            r_row_sel    <= w_row_sel_n;
            r_col_data   <= w_col_n;
            r_frame_done <= w_done_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_row_n    = r_row;
        w_capture  = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        w_done_n   = 1'b0;

        if (!en) begin
            w_state_n = S_LOAD;
            w_row_n   = '0;
            w_load    = 1'b1;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_capture = 1'b1;
                    w_row_n   = '0;
                    w_load    = 1'b1;
                    if (BLANK_CYCLES > 0) begin
                        w_state_n  = S_BLANK;
                        w_load_val = BLANK_LD;
                    end else begin
                        w_state_n  = S_SHOW;
                        w_load_val = DWELL_LD;
                    end
                end
                S_BLANK: begin
                    if (w_tmr_zero) begin
                        w_state_n  = S_SHOW;
                        w_load     = 1'b1;
                        w_load_val = DWELL_LD;
                    end
                end
                S_SHOW: begin
                    if (w_tmr_zero) begin
                        w_load = 1'b1;
                        if (r_row == LAST_ROW) begin
                            w_state_n = S_LOAD;
                            w_done_n  = 1'b1;
                        end else begin
                            w_row_n = r_row + ROW_ONE;
                            if (BLANK_CYCLES > 0) begin
                                w_state_n  = S_BLANK;
                                w_load_val = BLANK_LD;
                            end else begin
                                w_state_n  = S_SHOW;
                                w_load_val = DWELL_LD;
                            end
                        end
                    end
                end
                default: begin
                    w_state_n = S_LOAD;
                    w_row_n   = '0;
                end
            endcase
        end

        w_snap_n = w_capture ? grid : r_snap;

        // Drives are computed from the next state so they change on the same
        // edge as the state; with no blanking the first row shows the grid
        // being captured on that very edge.
        w_row_sel_n = '0;
        w_col_n     = '0;
        if (w_state_n == S_SHOW) begin
            w_row_sel_n[w_row_n] = 1'b1;
            w_col_n              = w_snap_n[w_row_n];
        end
    end

    assign row_sel    = r_row_sel;
    assign col_data   = r_col_data;
    assign frame_done = r_frame_done;

`ifdef GRID_STABLE_EN
    grid_t r_prev;
    logic  r_primed;
    logic  r_valid;

    // r_primed marks that a capture has happened since reset / en rising;
    // r_valid qualifies the snap/prev comparison, so stable only changes on
    // a LOAD edge and is forced low for the first capture of a run.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_valid  <= 1'b0;
        end else if (!en) begin
            r_primed <= 1'b0;
        end else if (w_capture) begin
            r_prev   <= r_snap;
            r_valid  <= r_primed;
            r_primed <= 1'b1;
        end
    end

    assign stable = r_valid && (r_snap == r_prev);
`else
    assign stable = 1'b0;
`endif

endmodule

// File: tb/tb_grid_scan.sv
// ----------------------------------------------------------------------------
// tb_grid_scan
// Directed bench for grid_scan. Two instances share clock and inputs:
//   u_a : ROW_DWELL=4, BLANK_CYCLES=1 (41-cycle frame)
//   u_b : ROW_DWELL=3, BLANK_CYCLES=0 (25-cycle frame)
// Honours GRID_STABLE_EN for the stable-output expectations.
// ----------------------------------------------------------------------------
module tb_grid_scan;
    import grid_pkg::*;

    localparam int DA = 4;
    localparam int BA = 1;
    localparam int FA = 1 + 8 * (BA + DA);
    localparam int DB = 3;
    localparam int BB = 0;
    localparam int FB = 1 + 8 * (BB + DB);
`ifdef GRID_STABLE_EN
    localparam logic SON = 1'b1;
`else
    localparam logic SON = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst_n;
    logic  en;
    grid_t grid;
    row_t  rs_a, cd_a, rs_b, cd_b;
    logic  fd_a, st_a, fd_b, st_b;

    int    n_total = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    base    = 0;
    grid_t esnap_a, esnap_b;

    always #5 clk = ~clk;

    grid_scan #(.ROW_DWELL(DA), .BLANK_CYCLES(BA)) u_a (
        .clk(clk), ._rst(rst_n), .en(en), .grid(grid),
        .row_sel(rs_a), .col_data(cd_a), .frame_done(fd_a), .stable(st_a)
    );

    grid_scan #(.ROW_DWELL(DB), .BLANK_CYCLES(BB)) u_b (
        .clk(clk), ._rst(rst_n), .en(en), .grid(grid),
        .row_sel(rs_b), .col_data(cd_b), .frame_done(fd_b), .stable(st_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_a_row_sel"}, rs_a, 8'h00);
        chk({tag, "_a_col_data"}, cd_a, 8'h00);
        chk({tag, "_a_frame_done"}, {7'b0, fd_a}, 8'h00);
        chk({tag, "_b_row_sel"}, rs_b, 8'h00);
        chk({tag, "_b_col_data"}, cd_b, 8'h00);
        chk({tag, "_b_frame_done"}, {7'b0, fd_b}, 8'h00);
        chk({tag, "_a_state_load"}, {6'b0, u_a.r_state}, {6'b0, S_LOAD});
    endtask

    // Reference frame walk: offset k within the run since the last restart.
    task automatic run(input int n);
        int   ka, kk, r, j;
        row_t ers, ecd;
        for (int i = 0; i < n; i++) begin
            ka = cyc - base;

            kk = ka % FA;
            ers = '0;
            ecd = '0;
            if (kk != 0) begin
                j = (kk - 1) % (BA + DA);
                r = (kk - 1) / (BA + DA);
                if (j >= BA) begin
                    ers[r] = 1'b1;
                    ecd    = esnap_a[r];
                end
            end
            chk("a_row_sel", rs_a, ers);
            chk("a_col_data", cd_a, ecd);
            chk("a_frame_done", {7'b0, fd_a}, {7'b0, (kk == 0 && ka > 0)});
            if (kk == 0) esnap_a = grid;

            kk = ka % FB;
            ers = '0;
            ecd = '0;
            if (kk != 0) begin
                j = (kk - 1) % (BB + DB);
                r = (kk - 1) / (BB + DB);
                if (j >= BB) begin
                    ers[r] = 1'b1;
                    ecd    = esnap_b[r];
                end
            end
            chk("b_row_sel", rs_b, ers);
            chk("b_col_data", cd_b, ecd);
            chk("b_frame_done", {7'b0, fd_b}, {7'b0, (kk == 0 && ka > 0)});
            if (kk != 0) chk("b_row_sel_nonzero", {7'b0, (rs_b != '0)}, 8'h01);
            if (kk == 0) esnap_b = grid;

`ifndef GRID_STABLE_EN
            chk("a_stable_off", {7'b0, st_a}, 8'h00);
            chk("b_stable_off", {7'b0, st_b}, 8'h00);
`endif
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        for (int r = 0; r < 8; r++) grid[r] = (r % 2 == 0) ? 8'hAA : 8'h55;

        // Reset state
        tick();
        tick();
        all_zero("reset");
        chk("reset_a_stable", {7'b0, st_a}, 8'h00);
        chk("reset_b_stable", {7'b0, st_b}, 8'h00);

        // Checkerboard frames; grid goes all-ones on cycle 10 of the third
        // u_a frame (starting at cycle 82).
        rst_n = 1'b1;
        cyc   = 0;
        base  = 0;
        run(2);
        chk("a_row0_lit_sel", rs_a, 8'h80);
        chk("a_row0_lit_col", cd_a, 8'hAA);
        run(90);
        for (int r = 0; r < 8; r++) grid[r] = 8'hFF;
        run(59);

        // cycle 151: u_a row 5 lit from the all-ones frame captured at 123
        chk("a_row5_sel", rs_a, 8'h04);
        chk("a_row5_col", cd_a, 8'hFF);

        // One-cycle reset during row 5, fresh grid captured on restart
        rst_n = 1'b0;
        for (int r = 0; r < 8; r++) grid[r] = 8'h01 << r;
        tick();
        all_zero("midreset");
        chk("midreset_a_stable", {7'b0, st_a}, 8'h00);
        rst_n = 1'b1;
        base  = cyc;
        run(3);
        chk("restart_a_row0_col", cd_a, 8'h01);
        run(47);

        // Enable low for 5 cycles
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            all_zero("en_low");
        end
        en = 1'b1;
        for (int r = 0; r < 8; r++) grid[r] = 8'h80 >> r;
        base = cyc;
        run(45);

        // Still-life block at rows 3-4, cols 3-4
        rst_n = 1'b0;
        grid  = '0;
        grid[3][3] = 1'b1;
        grid[3][4] = 1'b1;
        grid[4][3] = 1'b1;
        grid[4][4] = 1'b1;
        tick();
        rst_n = 1'b1;
        base  = cyc;
        run(1);
        chk("stable_a_first", {7'b0, st_a}, 8'h00);
        chk("stable_b_first", {7'b0, st_b}, 8'h00);
        run(25);
        chk("stable_b_second", {7'b0, st_b}, {7'b0, SON});
        run(16);
        chk("stable_a_second", {7'b0, st_a}, {7'b0, SON});
        run(3);
        grid[3][3] = 1'b0;
        run(6);
        chk("stable_b_changed", {7'b0, st_b}, 8'h00);
        run(32);
        chk("stable_a_changed", {7'b0, st_a}, 8'h00);
        run(41);
        chk("stable_a_resettle", {7'b0, st_a}, {7'b0, SON});

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/grid_scan.md
# grid_scan

Row-multiplexed LED driver for the 8x8 Game-of-Life array. Consumes the `grid` bus produced by the cell matrix, captures a tear-free snapshot once per display frame, and scans it one row at a time onto an 8x8 common-row LED matrix with programmable dwell and anti-ghosting blanking. It sits directly downstream of the matrix and upstream of the board pins.

## Interface
- `ROW_DWELL`, 1000: cycles each row is lit; legal range is 1 or more.
- `BLANK_CYCLES`, 2: cycles with all rows off before each row is lit; legal range is 0 or more.
- `clk`  in  1  sole clock, rising edge.
- `_rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  scan enable; low blanks the display and restarts the frame.
- `grid`  in  [0:7][0:7]  live-cell array from the matrix; `grid[r][c]`, where 1 means alive.
- `row_sel`  out  [0:7]  one-hot row drive, active-high; all zero while blanking.
- `col_data`  out  [0:7]  column drive for the lit row; `col_data[c] = snap[r][c]`.
- `frame_done`  out  1  single-cycle pulse at the end of each frame.
- `stable`  out  1  high when the last two snapshots are identical. Only meaningful with `GRID_STABLE_EN`.

## Operation
- State machine:
  - LOAD → BLANK → SHOW → (next row) BLANK … ; after row 7 SHOW → LOAD.
  - LOAD lasts 1 cycle. At its clock edge it copies `grid` into the 64-bit `snap` register and sets `row_idx` to 0.
  - BLANK lasts `BLANK_CYCLES` cycles, with `row_sel` = 0 and `col_data` = 0. When `BLANK_CYCLES` = 0, BLANK is skipped and the machine goes SHOW → SHOW directly.
  - SHOW lasts `ROW_DWELL` cycles, with `row_sel` one-hot at `row_idx` (`row_sel[row_idx]` = 1) and `col_data = snap[row_idx]`.
- Snapshot rules:
  - `snap` changes only in LOAD, so a frame never mixes two generations.
  - `grid` is sampled only at the LOAD edge.
- Timer: a single down-counter reloaded on each state entry, sized `$clog2(max(ROW_DWELL, BLANK_CYCLES, 1)+1)` bits.
- `frame_done`: registered; high during the LOAD cycle that follows a completed frame. It is not asserted on the first LOAD after reset or after `en` rises.
- `en` low:
  - Takes effect at the next edge: state goes to LOAD, `row_idx` goes to 0, and `row_sel`, `col_data` and `frame_done` go to 0.
  - While `en` stays low, the block holds in LOAD without capturing.
  - When `en` rises, the first LOAD captures and a fresh frame starts.
- `_rst` low at any edge, including mid-frame:
  - State goes to LOAD, `row_idx` and the timer go to 0, and `snap` is cleared.
  - All outputs are 0 after that edge: `row_sel`, `col_data`, `frame_done`, `stable`.
  - Reset takes priority over `en`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Frame length is 1 + 8·(`BLANK_CYCLES` + `ROW_DWELL`) cycles.
- LOAD at cycle t → first BLANK cycle of row 0 at t+1 → row 0 lit from t+1+`BLANK_CYCLES`.
- `row_sel` and `col_data` update on the same edge. Row changes always pass through an all-zero `row_sel` whenever `BLANK_CYCLES` ≥ 1.
- `grid` changes on any cycle other than the LOAD edge have no effect on the outputs until the next frame.

## Configuration
- Macro: `GRID_STABLE_EN`.
- Defined:
  - Adds a 64-bit `prev` register. At each LOAD edge, `prev` takes the old `snap`.
  - `stable` is registered as (new `snap` == old `snap`) on that same edge and holds until the next LOAD.
  - The first capture after reset or after `en` rises forces `stable` = 0.
- Undefined: no `prev` register, and `stable` is tied to 0.

## Structure
- Shared package `grid_pkg`:
  - `GRID_N = 8`.
  - `typedef logic [0:GRID_N-1][0:GRID_N-1] grid_t`, also used by the matrix output.
  - `typedef enum {S_LOAD, S_BLANK, S_SHOW} scan_state_t`.
- One sub-module, `scan_timer`: a loadable down-counter with a zero flag, parameterised on width. The FSM, snapshot and comparison logic stay in `grid_scan`.

## Test plan
- Frame sequence (`ROW_DWELL`=4, `BLANK_CYCLES`=1, `en`=1, `grid` = checkerboard `8'hAA`/`8'h55` rows):
  - The frame is 41 cycles.
  - `row_sel` walks rows 0 to 7, 4 cycles each, with 1 zero cycle before each row.
  - `col_data` alternates AA/55.
  - `frame_done` pulses once every 41 cycles.
- Snapshot integrity: change `grid` to all-ones on cycle 10 of a frame. `col_data` keeps the old rows for the rest of the frame and shows FF only after the next LOAD.
- Zero blanking (`BLANK_CYCLES`=0, `ROW_DWELL`=3): the frame is 25 cycles, and `row_sel` is never all-zero during SHOW.
- Reset and enable:
  - Pulse `_rst`=0 for 1 cycle during row 5. The next cycle has all outputs 0 and the state in LOAD; row 0 restarts from the fresh capture.
  - Drop `en` for 5 cycles. Outputs stay 0 with no `frame_done`, and the frame restarts at row 0 after `en` rises.
- `GRID_STABLE_EN` (block still-life at rows 3–4, cols 3–4):
  - `stable` = 0 after the first LOAD and 1 after the second.
  - Change one cell: `stable` is 0 at the next LOAD.
  - Without the macro, `stable` stays 0 throughout.
